pwm_cfg_sequencer: RTL and testbench

PWM_CFG_SEQUENCER -- requirements
Module: pwm_cfg_sequencer

---
 rtl/pwm_cfg_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_sequencer.sv
// rtl/pwm_cfg_sequencer.sv - Wishbone master that programs and verifies a PWM timer
//
// Accepts one configuration request at a time and performs a fixed six-access
// Wishbone classic sequence: stop write of ctrl, divisor, period, duty cycle,
// final ctrl write, then a ctrl readback that is compared to what was written.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_cfg_valid / o_cfg_ready    request handshake (ready only while idle)
//   i_cfg_ctrl/div/period/dc     request fields, captured at acceptance
//   o_wb_cyc/stb/we/adr/data     Wishbone master outputs
//   i_wb_ack, i_wb_data          Wishbone slave ack and read data
//   o_busy                       request in progress
//   o_done / o_err               one-cycle completion / failure pulses
//   o_err_code                   01 timeout, 10 readback mismatch, 11 invalid
module pwm_cfg_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic [7:0]  i_cfg_ctrl,
    input  logic [15:0] i_cfg_div,
    input  logic [15:0] i_cfg_period,
    input  logic [15:0] i_cfg_dc,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_adr,
    output logic [15:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [15:0] i_wb_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    localparam logic [7:0] TMO_LIMIT = TIMEOUT[7:0];
    localparam logic [2:0] LAST_IDX  = 3'd5;

    // S_FIN doubles as the gap after the final access and carries the pulse.
    typedef enum logic [1:0] {
        S_IDLE,
        S_STB,
        S_GAP,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic [15:0] per_q, per_d;
    logic [15:0] dc_q, dc_d;
    logic        fail_q, fail_d;
    logic [1:0]  code_q, code_d;

    logic        req_invalid;
    logic        rb_ok;

    assign req_invalid = (i_cfg_div == 16'd0) ||
                         (i_cfg_ctrl[1] && (i_cfg_dc > i_cfg_period));

    // Bit5 is an irq flag the timer may set on its own, so it is excluded.
    assign rb_ok = (i_wb_data[15:8] == 8'h00) &&
                   (((i_wb_data[7:0] ^ ctrl_q) & 8'hDF) == 8'h00);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            timer_q <= 8'd0;
            ctrl_q  <= 8'd0;
            div_q   <= 16'd0;
            per_q   <= 16'd0;
            dc_q    <= 16'd0;
            fail_q  <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            per_q   <= per_d;
            dc_q    <= dc_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        per_d   = per_q;
        dc_d    = dc_q;
        fail_d  = fail_q;
        code_d  = code_q;

        case (state_q)
            S_IDLE: begin
                if (i_cfg_valid) begin
                    ctrl_d  = i_cfg_ctrl;
                    div_d   = i_cfg_div;
                    per_d   = i_cfg_period;
                    dc_d    = i_cfg_dc;
                    idx_d   = 3'd0;
                    timer_d = 8'd0;
                    if (req_invalid) begin
                        fail_d  = 1'b1;
                        code_d  = 2'b11;
                        state_d = S_FIN;
                    end else begin
                        fail_d  = 1'b0;
                        code_d  = 2'b00;
                        state_d = S_STB;
                    end
                end
            end
            S_STB: begin
                if (i_wb_ack) begin
                    timer_d = 8'd0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FIN;
                        if (!rb_ok) begin
                            fail_d = 1'b1;
                            code_d = 2'b10;
                        end
                    end else begin
                        state_d = S_GAP;
                    end
                end else if ((timer_q + 8'd1) == TMO_LIMIT) begin
                    fail_d  = 1'b1;
                    code_d  = 2'b01;
                    state_d = S_FIN;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_GAP: begin
                idx_d   = idx_q + 3'd1;
                timer_d = 8'd0;
                state_d = S_STB;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs decode from registered state so reset clears them at once.
    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_adr  = 4'h0;
        o_wb_data = 16'h0000;
        if (state_q == S_STB) begin
            o_wb_cyc = 1'b1;
            o_wb_stb = 1'b1;
            case (idx_q)
                3'd0: begin
                    o_wb_we   = 1'b1;
                    o_wb_adr  = 4'h0;
                    o_wb_data = {8'h00, ctrl_q & 8'hDB};
                end
                3'd1: begin
                    o_wb_we   = 1'b1;
                    o_wb_adr  = 4'h2;
                    o_wb_data = div_q;
                end
                3'd2: begin
                    o_wb_we   = 1'b1;
                    o_wb_adr  = 4'h4;
                    o_wb_data = per_q;
                end
                3'd3: begin
                    o_wb_we   = 1'b1;
                    o_wb_adr  = 4'h6;
                    o_wb_data = dc_q;
                end
                3'd4: begin
                    o_wb_we   = 1'b1;
                    o_wb_adr  = 4'h0;
                    o_wb_data = {8'h00, ctrl_q & 8'hDF};
                end
                default: begin
                    o_wb_we   = 1'b0;
                    o_wb_adr  = 4'h0;
                    o_wb_data = 16'h0000;
                end
            endcase
        end
    end

    assign o_cfg_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_FIN) && !fail_q;
    assign o_err       = (state_q == S_FIN) && fail_q;
    assign o_err_code  = code_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// tb/tb_pwm_cfg_sequencer.sv - self-checking bench for pwm_cfg_sequencer
module tb_pwm_cfg_sequencer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cfg_valid = 1'b0;
    logic        o_cfg_ready;
    logic [7:0]  i_cfg_ctrl = 8'h00;
    logic [15:0] i_cfg_div = 16'h0, i_cfg_period = 16'h0, i_cfg_dc = 16'h0;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [3:0]  o_wb_adr;
    logic [15:0] o_wb_data;
    logic        ack = 1'b0;
    logic [15:0] rdata = 16'h0;
    logic        o_busy, o_done, o_err;
    logic [1:0]  o_err_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_cfg_sequencer #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_ctrl(i_cfg_ctrl), .i_cfg_div(i_cfg_div),
        .i_cfg_period(i_cfg_period), .i_cfg_dc(i_cfg_dc),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data),
        .i_wb_ack(ack), .i_wb_data(rdata),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  adr;
        logic [15:0] data;
    } acc_t;

    acc_t log_q[$];

    // Slave model: registered ack after slv_wait extra cycles, optional
    // extra ack hold into the gap, optional never-ack on one access index.
    int          slv_wait = 0, slv_hold = 0, slv_nack = -1;
    bit          slv_force = 0, slv_hw5 = 0;
    logic [15:0] slv_force_val = 16'h0;
    logic [7:0]  mem_ctrl = 8'h00;
    int          wcnt = 0, hold_cnt = 0;

    always @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            ack      <= 1'b0;
            wcnt     <= 0;
            hold_cnt <= 0;
        end else begin
            if (o_wb_cyc && o_wb_stb && ack) begin
                log_q.push_back({o_wb_we, o_wb_adr, o_wb_data});
                if (o_wb_we && o_wb_adr == 4'h0) mem_ctrl <= o_wb_data[7:0];
            end
            if (hold_cnt > 0) begin
                ack      <= 1'b1;
                hold_cnt <= hold_cnt - 1;
            end else if (o_wb_cyc && o_wb_stb && !ack && log_q.size() != slv_nack) begin
                if (wcnt == slv_wait) begin
                    ack      <= 1'b1;
                    wcnt     <= 0;
                    hold_cnt <= slv_hold;
                    if (o_wb_we) rdata <= 16'h0;
                    else if (slv_force) rdata <= slv_force_val;
                    else rdata <= {8'h00, mem_ctrl | (slv_hw5 ? 8'h20 : 8'h00)};
                end else begin
                    ack  <= 1'b0;
                    wcnt <= wcnt + 1;
                end
            end else begin
                ack <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    int last_pulse_cyc;
    int last_stb_cycles;

    // Model: each access occupies (wait+2) strobe cycles plus one gap cycle,
    // a never-acked access holds strobe for TIMEOUT cycles, and the pulse
    // lands one cycle after the last strobe cycle.
    task automatic run(input logic [7:0] ctrl, input logic [15:0] div, input logic [15:0] per,
                       input logic [15:0] dc, input int w, input int hold, input int nack,
                       input bit frc, input logic [15:0] fval, input bit hw5,
                       input int inj, input int rst_at);
        bit          invalid, ok;
        int          nacc, p, ia;
        logic [1:0]  code;
        logic [15:0] rd;
        acc_t        exp_acc[6];

        invalid = (div == 16'd0) || (ctrl[1] && dc > per);
        exp_acc[0] = {1'b1, 4'h0, 8'h00, ctrl & ~8'h24};
        exp_acc[1] = {1'b1, 4'h2, div};
        exp_acc[2] = {1'b1, 4'h4, per};
        exp_acc[3] = {1'b1, 4'h6, dc};
        exp_acc[4] = {1'b1, 4'h0, 8'h00, ctrl & ~8'h20};
        exp_acc[5] = {1'b0, 4'h0, 16'h0000};
        if (invalid) begin
            nacc = 0; p = 1; ok = 0; code = 2'b11;
        end else if (nack >= 0) begin
            nacc = nack + 1; p = nack * (w + 3) + TMO + 1; ok = 0; code = 2'b01;
        end else begin
            nacc = 6; p = 6 * (w + 3);
            rd = frc ? fval : {8'h00, (ctrl & ~8'h20) | (hw5 ? 8'h20 : 8'h00)};
            ok = (rd[15:8] == 8'h00) && ((rd[7:0] & ~8'h20) == (ctrl & ~8'h20));
            code = ok ? 2'b00 : 2'b10;
        end

        slv_wait = w; slv_hold = hold; slv_nack = nack;
        slv_force = frc; slv_force_val = fval; slv_hw5 = hw5;
        log_q.delete();
        last_pulse_cyc = -1;
        last_stb_cycles = 0;

        @(negedge clk);
        chk("ready_before_req", o_cfg_ready, 1);
        i_cfg_ctrl = ctrl; i_cfg_div = div; i_cfg_period = per; i_cfg_dc = dc;
        i_cfg_valid = 1'b1;
        @(posedge clk);
        #1 i_cfg_valid = 1'b0;

        for (int c = 1; c <= p + 1; c++) begin
            @(negedge clk);
            ia = -1;
            for (int i = 0; i < nacc; i++) begin
                int s, len;
                s = i * (w + 3) + 1;
                len = (i == nack) ? TMO : (w + 2);
                if (c >= s && c < s + len) ia = i;
            end
            if (o_done || o_err) last_pulse_cyc = c;
            if (o_wb_stb) last_stb_cycles++;
            chk("busy", o_busy, (c <= p));
            chk("ready", o_cfg_ready, (c > p));
            chk("done", o_done, (c == p && ok));
            chk("err", o_err, (c == p && !ok));
            chk("err_code", o_err_code, (c >= p) ? code : 2'b00);
            chk("stb", o_wb_stb, (ia >= 0));
            chk("cyc", o_wb_cyc, (ia >= 0));
            if (ia >= 0) chk("bus_fields", {o_wb_we, o_wb_adr, o_wb_data}, exp_acc[ia]);
            if (c == inj) begin
                i_cfg_ctrl = 8'hFF; i_cfg_div = 16'h0; i_cfg_valid = 1'b1;
            end else begin
                i_cfg_valid = 1'b0;
            end
            if (c == rst_at) begin
                #2 i_rst = 1'b1;
                #1;
                chk("rst_cyc", o_wb_cyc, 0);
                chk("rst_stb", o_wb_stb, 0);
                chk("rst_outs", {o_wb_we, o_wb_adr, o_wb_data, o_busy, o_done, o_err, o_err_code}, 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_no_pulse", {o_done, o_err}, 0);
                end
                i_rst = 1'b0;
                @(negedge clk);
                chk("rst_ready", o_cfg_ready, 1);
                chk("rst_no_pulse_after", {o_done, o_err, o_busy}, 0);
                return;
            end
        end

        chk("access_count", log_q.size(), (nack >= 0) ? nack : nacc);
        for (int i = 0; i < log_q.size() && i < 6; i++)
            chk($sformatf("access_%0d", i), log_q[i], exp_acc[i]);
    endtask

    initial begin
        i_rst = 1'b1;
        #12;
        chk("reset_outs", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data,
                           o_busy, o_done, o_err, o_err_code}, 0);
        chk("reset_ready", o_cfg_ready, 1);
        @(negedge clk);
        i_rst = 1'b0;

        // Nominal configuration, timer sets irq flag on readback.
        run(8'h16, 16'd4, 16'd1000, 16'd250, 0, 0, -1, 0, 16'h0, 1, 0, 0);
        chk("lit_done_cycle", last_pulse_cyc, 18);
        chk("lit_stb_cycles", last_stb_cycles, 12);
        chk("lit_stop_ctrl", log_q[0].data, 16'h0012);
        chk("lit_final_ctrl", log_q[4].data, 16'h0016);
        chk("lit_code", o_err_code, 2'b00);

        // Invalid requests.
        run(8'h16, 16'd0, 16'd1000, 16'd250, 0, 0, -1, 0, 16'h0, 0, 0, 0);
        chk("lit_invalid_cycle", last_pulse_cyc, 1);
        chk("lit_invalid_code", o_err_code, 2'b11);
        run(8'h06, 16'd10, 16'd100, 16'd200, 0, 0, -1, 0, 16'h0, 0, 0, 0);
        chk("lit_invalid2_code", o_err_code, 2'b11);

        // div==1 and dc==period are valid; dc>period valid when mode bit clear.
        run(8'h02, 16'd1, 16'd100, 16'd100, 0, 0, -1, 0, 16'h0, 0, 0, 0);
        run(8'h24, 16'd3, 16'd10, 16'd50, 0, 0, -1, 0, 16'h0, 1, 0, 0);
        chk("lit_stop_ctrl2", log_q[0].data, 16'h0000);

        // Divisor write never acked.
        run(8'h16, 16'd4, 16'd1000, 16'd250, 0, 0, 1, 0, 16'h0, 0, 0, 0);
        chk("lit_tmo_cycle", last_pulse_cyc, 20);
        chk("lit_tmo_stb_cycles", last_stb_cycles, 18);
        chk("lit_tmo_code", o_err_code, 2'b01);

        // Readback mismatch and accepted hardware irq bit.
        run(8'h16, 16'd4, 16'd1000, 16'd250, 0, 0, -1, 1, 16'h0012, 0, 0, 0);
        chk("lit_rb_code", o_err_code, 2'b10);
        run(8'h16, 16'd4, 16'd1000, 16'd250, 0, 0, -1, 1, 16'h0036, 0, 0, 0);
        chk("lit_rb36_code", o_err_code, 2'b00);
        run(8'h16, 16'd4, 16'd1000, 16'd250, 0, 0, -1, 1, 16'h0116, 0, 0, 0);
        chk("lit_rb_hi_code", o_err_code, 2'b10);

        // Trailing ack, wait states with a request attempted while busy.
        run(8'h16, 16'd7, 16'd300, 16'd30, 0, 1, -1, 0, 16'h0, 0, 0, 0);
        run(8'h16, 16'd7, 16'd300, 16'd30, 3, 0, -1, 0, 16'h0, 0, 5, 0);
        chk("lit_wait_done_cycle", last_pulse_cyc, 36);

        // Reset during the period write, then a full sequence.
        run(8'h16, 16'd4, 16'd1000, 16'd250, 0, 0, -1, 0, 16'h0, 0, 0, 8);
        run(8'h16, 16'd4, 16'd1000, 16'd250, 0, 0, -1, 0, 16'h0, 1, 0, 0);
        chk("lit_post_rst_done", last_pulse_cyc, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
